// File: rtl/mnacidpro_sequencer_pkg.sv
// Shared types and valve maps for the nucleic-acid purification sequencer.
// Valve bits are 1 when pressurised (closed); the masks below mark the open ones.
package mnacidpro_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BEAD    = 3'd1,
    S_LYSIS   = 3'd2,
    S_WASH    = 3'd3,
    S_ELUTE   = 3'd4,
    S_COLLECT = 3'd5
  } state_t;

  localparam int NUM_VALVES = 11;
  localparam int NUM_STEPS  = 5;

  localparam int V_LYSIS     = 0;
  localparam int V_WASH      = 1;
  localparam int V_ELUTE     = 2;
  localparam int V_DEAD_END  = 3;
  localparam int V_VERTICAL  = 4;
  localparam int V_HORIZ     = 5;
  localparam int V_WASTE     = 6;
  localparam int V_BEAD      = 7;
  localparam int V_LOOP_EXIT = 8;
  localparam int V_BEAD_TRAP = 9;
  localparam int V_COLLECT   = 10;

  localparam logic [NUM_VALVES-1:0] ONE_HOT = NUM_VALVES'(1);

  localparam logic [NUM_VALVES-1:0] OPEN_BEAD =
    (ONE_HOT << V_BEAD) | (ONE_HOT << V_VERTICAL) | (ONE_HOT << V_WASTE);
  localparam logic [NUM_VALVES-1:0] OPEN_LYSIS =
    (ONE_HOT << V_LYSIS) | (ONE_HOT << V_HORIZ) | (ONE_HOT << V_LOOP_EXIT);
  localparam logic [NUM_VALVES-1:0] OPEN_WASH =
    (ONE_HOT << V_WASH) | (ONE_HOT << V_HORIZ) | (ONE_HOT << V_WASTE);
  localparam logic [NUM_VALVES-1:0] OPEN_ELUTE =
    (ONE_HOT << V_ELUTE) | (ONE_HOT << V_HORIZ) | (ONE_HOT << V_LOOP_EXIT);
  localparam logic [NUM_VALVES-1:0] OPEN_COLLECT =
    (ONE_HOT << V_LOOP_EXIT) | (ONE_HOT << V_COLLECT);

  function automatic logic [NUM_VALVES-1:0] open_mask(input state_t s);
    open_mask = '0;
    case (s)
      S_BEAD:    open_mask = OPEN_BEAD;
      S_LYSIS:   open_mask = OPEN_LYSIS;
      S_WASH:    open_mask = OPEN_WASH;
      S_ELUTE:   open_mask = OPEN_ELUTE;
      S_COLLECT: open_mask = OPEN_COLLECT;
      default:   open_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/mnacidpro_sequencer_phaser.sv
// N-phase peristaltic pump driver: walks one closed-valve gap around the pump ring.
// enable/clear describe the coming cycle so the pump pattern can be registered.
module peristaltic_pump_phaser
  import mnacidpro_pkg::*;
#(
  parameter int PUMP_PHASES = 3,
  parameter int PHASE_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [PHASE_W-1:0]     phase_cycles,
  output logic [PUMP_PHASES-1:0] pump,
  output logic                   stroke_tick
);

  localparam int PH_W = (PUMP_PHASES > 1) ? $clog2(PUMP_PHASES) : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PUMP_PHASES - 1);

  logic [PHASE_W-1:0]     cyc_q, cyc_d, last_cyc;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic                   active_q, active_d;
  logic [PUMP_PHASES-1:0] pump_q, pump_d;
  logic                   phase_end;

  always_comb begin
    last_cyc    = (phase_cycles == '0) ? '0 : phase_cycles - 1'b1;
    phase_end   = active_q && (cyc_q == last_cyc);
    stroke_tick = phase_end && (phase_q == LAST_PHASE);

    cyc_d   = cyc_q;
    phase_d = phase_q;
    if (clear) begin
      cyc_d   = '0;
      phase_d = '0;
    end else if (active_q) begin
      if (phase_end) begin
        cyc_d   = '0;
        phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end

    active_d = enable;
    pump_d   = '1;
    if (enable) pump_d[phase_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= '0;
      phase_q  <= '0;
      active_q <= 1'b0;
      pump_q   <= '1;
    end else begin
      cyc_q    <= cyc_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      pump_q   <= pump_d;
    end
  end

  assign pump = pump_q;

endmodule

// File: rtl/mnacidpro_sequencer.sv
// Timed valve/pump sequencer: BEAD, LYSIS, WASH, ELUTE, COLLECT, each a configurable
// number of pump strokes. All outputs come straight from flops loaded with next-state values.
module mnacidpro_sequencer
  import mnacidpro_pkg::*;
#(
  parameter int SIZE        = 7,
  parameter int PUMP_PHASES = 3,
  parameter int PHASE_W     = 16,
  parameter int STROKE_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [$clog2(SIZE)-1:0]   chan,
  input  logic [PHASE_W-1:0]        cfg_phase_cycles,
  input  logic [5*STROKE_W-1:0]     cfg_strokes,
  output logic [NUM_VALVES-1:0]     valve,
  output logic [PUMP_PHASES-1:0]    pump,
  output logic [SIZE-1:0]           collect_sel,
  output logic [2:0]                step,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int CW = $clog2(SIZE);

  state_t                  state_q, state_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [PHASE_W-1:0]      pc_q, pc_d;
  logic [5*STROKE_W-1:0]   strokes_q, strokes_d;
  logic [STROKE_W-1:0]     stroke_q, stroke_d;
  logic [STROKE_W-1:0]     cur_target, next_target;
  logic [NUM_VALVES-1:0]   valve_q, valve_d;
  logic [SIZE-1:0]         collect_sel_q, collect_sel_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                    start_ok, start_bad, step_last;
  logic                    stroke_tick, ph_enable, ph_clear;

  function automatic logic [STROKE_W-1:0] strokes_for(input state_t s,
                                                      input logic [5*STROKE_W-1:0] v);
    strokes_for = '0;
    case (s)
      S_BEAD:    strokes_for = v[0*STROKE_W +: STROKE_W];
      S_LYSIS:   strokes_for = v[1*STROKE_W +: STROKE_W];
      S_WASH:    strokes_for = v[2*STROKE_W +: STROKE_W];
      S_ELUTE:   strokes_for = v[3*STROKE_W +: STROKE_W];
      S_COLLECT: strokes_for = v[4*STROKE_W +: STROKE_W];
      default:   strokes_for = '0;
    endcase
  endfunction

  // abort outranks everything; a zero-stroke step still occupies one cycle
  always_comb begin
    start_ok   = (state_q == S_IDLE) && start && !abort && (int'(chan) <  SIZE);
    start_bad  = (state_q == S_IDLE) && start && !abort && (int'(chan) >= SIZE);
    cur_target = strokes_for(state_q, strokes_q);
    step_last  = (cur_target == '0) ||
                 (stroke_tick && ((stroke_q + STROKE_W'(1)) == cur_target));

    state_d   = state_q;
    chan_d    = chan_q;
    pc_d      = pc_q;
    strokes_d = strokes_q;
    stroke_d  = stroke_q;
    done_d    = 1'b0;

    if (state_q == S_IDLE) begin
      if (start_ok) begin
        chan_d    = chan;
        pc_d      = cfg_phase_cycles;
        strokes_d = cfg_strokes;
        state_d   = S_BEAD;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      if (stroke_tick) stroke_d = stroke_q + 1'b1;
      if (step_last) begin
        case (state_q)
          S_BEAD:  state_d = S_LYSIS;
          S_LYSIS: state_d = S_WASH;
          S_WASH:  state_d = S_ELUTE;
          S_ELUTE: state_d = S_COLLECT;
          default: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
    end

    ph_clear = (state_d != state_q);
    if (ph_clear) stroke_d = '0;

    next_target   = strokes_for(state_d, strokes_d);
    ph_enable     = (state_d != S_IDLE) && (next_target != '0);
    valve_d       = ~open_mask(state_d);
    collect_sel_d = (state_d == S_COLLECT) ? (SIZE'(1) << chan_d) : '0;
    busy_d        = (state_d != S_IDLE);
    err_d         = start_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      chan_q        <= '0;
      pc_q          <= '0;
      strokes_q     <= '0;
      stroke_q      <= '0;
      valve_q       <= '1;
      collect_sel_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      chan_q        <= chan_d;
      pc_q          <= pc_d;
      strokes_q     <= strokes_d;
      stroke_q      <= stroke_d;
      valve_q       <= valve_d;
      collect_sel_q <= collect_sel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  peristaltic_pump_phaser #(
    .PUMP_PHASES (PUMP_PHASES),
    .PHASE_W     (PHASE_W)
  ) u_phaser (
    .clk          (clk),
    .rst          (rst),
    .enable       (ph_enable),
    .clear        (ph_clear),
    .phase_cycles (pc_q),
    .pump         (pump),
    .stroke_tick  (stroke_tick)
  );

  assign valve       = valve_q;
  assign collect_sel = collect_sel_q;
  assign step        = state_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/mnacidpro_sequencer.md
Name: mnacidpro_sequencer

Overview:
Timed valve/pump sequencer for the parametrised nucleic-acid purification chip. It drives every control pad, the N-phase peristaltic pump and a one-hot selector over SIZE collection outlets. It steps through bead load, lysis, wash, elute and collect, running a configurable number of pump strokes in each step. It sits between the host command interface and the chip's ctrl pads; flush pads stay outside this block.

Parameters:
SIZE, 7, number of collection outlets; the collect_sel width.
PUMP_PHASES, 3, number of pump valves; one stroke = PUMP_PHASES phases.
PHASE_W, 16, width of the phase-duration counter.
STROKE_W, 8, width of each per-step stroke count.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle run request; honoured only in IDLE
abort  in  1  one-cycle request; returns to the safe state from any state
chan  in  $clog2(SIZE)  outlet index for this run; sampled with start
cfg_phase_cycles  in  PHASE_W  clock cycles per pump phase; sampled with start
cfg_strokes  in  5*STROKE_W  stroke counts; slice k belongs to step k (0=BEAD … 4=COLLECT); sampled with start
valve  out  11  control valves, 1=pressurised/closed; index map held in the package
pump  out  PUMP_PHASES  pump valves, 1=closed
collect_sel  out  SIZE  one-hot outlet select, 1=open
step  out  3  current state encoding
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset and IDLE values: valve=all 1, pump=all 1, collect_sel=0, step=IDLE, busy=0, done=0, err=0. Every closed state is the safe state.
- States run in this order: IDLE → BEAD → LYSIS → WASH → ELUTE → COLLECT → IDLE.
- Start handling:
  - start in IDLE with chan<SIZE: latch chan and cfg_*, then enter BEAD on the next clock.
  - start in IDLE with chan≥SIZE: pulse err, stay in IDLE.
  - start while busy: ignored, no err.
- Per-state open valves (all others 1):
  - BEAD: bead, vertical, waste.
  - LYSIS: lysis, horiz, loop_exit.
  - WASH: wash, horiz, waste.
  - ELUTE: elute, horiz, loop_exit.
  - COLLECT: loop_exit, collect; collect_sel=1<<chan_latched.
  - collect_sel is 0 in every state except COLLECT.
- Pump pattern:
  - During phase p (0..PUMP_PHASES-1) of an active step, pump[p]=0 and all other pump bits are 1.
  - p advances after cfg_phase_cycles cycles; a latched value of 0 is treated as 1.
  - After phase PUMP_PHASES-1 completes, the stroke counter increments and p wraps to 0.
- Step timing:
  - A step lasts strokes_k*PUMP_PHASES*max(cfg_phase_cycles,1) cycles.
  - If strokes_k=0, the step lasts exactly 1 cycle with pump all 1; valves still show that step's pattern.
  - Phase and stroke counters clear on every state entry.
- Completion: in the last cycle of COLLECT, the next state is IDLE and done pulses in that same first IDLE cycle (registered). Outputs return to the safe state in that cycle.
- Abort:
  - Takes priority over every other event, including the final COLLECT cycle.
  - Next cycle is IDLE with safe outputs; no done pulse.
  - abort in IDLE has no effect.
  - Simultaneous start+abort in IDLE: abort wins, start is dropped.
- Config changes while busy have no effect until the next start.
- Reset mid-run: outputs go to the safe values immediately (asynchronous); counters and latched config clear.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package mnacidpro_pkg holds:
  - state enum: IDLE, BEAD, LYSIS, WASH, ELUTE, COLLECT.
  - valve index constants: LYSIS=0, WASH=1, ELUTE=2, DEAD_END=3, VERTICAL=4, HORIZ=5, WASTE=6, BEAD=7, LOOP_EXIT=8, BEAD_TRAP=9, COLLECT=10.
  - per-state open-mask constants (11 bits each).
- One sub-module, peristaltic_pump_phaser:
  - Parameters PUMP_PHASES and PHASE_W.
  - Inputs: enable, clear, phase_cycles.
  - Outputs: pump vector and a stroke_tick pulse.
  - The sequencer counts stroke_tick against strokes_k.

Test Plan:
- Reset, then idle 10 cycles → valve=11'h7FF, pump=3'b111, collect_sel=0, busy=0.
- SIZE=7, chan=3, phase_cycles=2, strokes all 1, start → BEAD 6 cycles with pump sequence 110,110,101,101,011,011; then LYSIS, WASH, ELUTE; then COLLECT with collect_sel=7'b0001000; done 1 cycle after COLLECT's 6th cycle; 30 busy cycles total.
- strokes={0,0,2,0,0}, phase_cycles=0 → BEAD, LYSIS, ELUTE, COLLECT 1 cycle each; WASH 6 cycles (phase=1 cycle); done after 10 busy cycles.
- start with chan=7 (SIZE=7) → err pulses 1 cycle, busy stays 0. Re-issue start during a run → ignored, no err.
- abort in the 3rd cycle of WASH → next cycle all valves and pump 1, busy=0, no done. start+abort together in IDLE → stays IDLE.
- Assert rst in the middle of ELUTE → outputs safe in the same cycle. After release, start with chan=6 → COLLECT drives collect_sel=7'b1000000.
